// File: rtl/fsm_pkgs.sv
// ============================================================================
//  Module      : fsm_pkgs
//  Description : Shared FSM state encodings and default block geometry.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package fsm_pkgs;

    localparam int c_NUM_BYTES = 8;
    localparam int c_BYTE_W    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } fsm_64to8_state_encoding;

endpackage

`default_nettype wire

// File: rtl/fsm_64to8.sv
// ============================================================================
//  Module      : fsm_64to8
//  Description : Splits wide blocks into bytes, MSB byte first, for a UART TX,
//                with a one-entry holding register for the next block.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fsm_64to8
    import fsm_pkgs::*;
#(
    parameter int NUM_BYTES = c_NUM_BYTES,
    parameter int BYTE_W    = c_BYTE_W
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_BYTES*BYTE_W-1:0]   data_in,
    input  logic                          data_valid,
    output logic                          in_ready,
    input  logic                          tx_done,
    output logic [BYTE_W-1:0]             byte_out,
    output logic                          tx_start,
    output logic                          busy,
    output logic                          block_done
);

    localparam int c_DATA_W = NUM_BYTES * BYTE_W;
    localparam int c_CNT_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(NUM_BYTES - 1);

    fsm_64to8_state_encoding r_state;
    fsm_64to8_state_encoding w_next_state;

    logic [c_DATA_W-1:0] r_shift_reg;
    logic [c_DATA_W-1:0] r_hold_reg;
    logic                r_hold_full;
    logic [c_CNT_W-1:0]  r_byte_count;

    logic w_accept;
    logic w_load;
    logic w_last;
    logic w_advance;

    assign w_accept  = data_valid && !r_hold_full;
    assign w_load    = (r_state == IDLE) && r_hold_full;
    assign w_last    = (r_byte_count == c_LAST);
    assign w_advance = (r_state == WAIT) && tx_done && !w_last;

    assign in_ready  = !r_hold_full;
    assign byte_out  = r_shift_reg[c_DATA_W-1 -: BYTE_W];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = IDLE;
        case (r_state)
            IDLE:    w_next_state = r_hold_full ? START : IDLE;
            START:   w_next_state = WAIT;
            WAIT: begin
                if (!tx_done) begin
                    w_next_state = WAIT;
                end else if (w_last) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = START;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        tx_start   = 1'b0;
        busy       = 1'b0;
        block_done = 1'b0;
        case (r_state)
            START: begin
                tx_start = 1'b1;
                busy     = 1'b1;
            end
            WAIT:  busy = 1'b1;
            DONE: begin
                block_done = 1'b1;
                busy       = 1'b1;
            end
            default: begin
                tx_start   = 1'b0;
                busy       = 1'b0;
                block_done = 1'b0;
            end
        endcase
    end

    // Accept only happens while the holder is empty and load only while it is
    // full, so the two never collide on the same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hold_reg  <= '0;
            r_hold_full <= 1'b0;
        end else if (w_accept) begin
            r_hold_reg  <= data_in;
            r_hold_full <= 1'b1;
        end else if (w_load) begin
            r_hold_full <= 1'b0;
        end
    end

    // The shift happens on the tx_done edge, so byte_out stays put for the
    // whole START..WAIT window of each byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shift_reg  <= '0;
            r_byte_count <= '0;
        end else if (w_load) begin
            r_shift_reg  <= r_hold_reg;
            r_byte_count <= '0;
        end else if (w_advance) begin
            r_shift_reg  <= r_shift_reg << BYTE_W;
            r_byte_count <= r_byte_count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fsm_64to8.sv
// ============================================================================
//  Module      : tb_fsm_64to8
//  Description : Self-checking bench for the 64-to-8 byte serializer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fsm_64to8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] data_in = '0;
    logic        data_valid = 1'b0;
    logic        in_ready;
    logic        tx_done;
    logic [7:0]  byte_out;
    logic        tx_start;
    logic        busy;
    logic        block_done;

    logic man_tx_done  = 1'b0;
    logic auto_tx_done = 1'b0;
    assign tx_done = man_tx_done | auto_tx_done;

    fsm_64to8 dut (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .in_ready   (in_ready),
        .tx_done    (tx_done),
        .byte_out   (byte_out),
        .tx_start   (tx_start),
        .busy       (busy),
        .block_done (block_done)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    bit auto_en = 1'b0;
    int gap_min = 1;
    int gap_max = 1;
    int bd_count = 0;
    int ts_count = 0;

    logic [7:0]  exp_q[$];
    logic [63:0] sent_q[$];
    logic [63:0] rx_q[$];

    typedef struct {
        logic [63:0] data;
        int          gap;
        logic [7:0]  exp_first;
        logic [7:0]  exp_last;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (block_done) bd_count++;
        if (tx_start)   ts_count++;
    end

    task automatic send_block(input logic [63:0] d);
        int w = 0;
        while (!in_ready && w < 500) begin
            tick();
            w++;
        end
        chk("send_in_ready_timeout", in_ready, 1);
        data_in    = d;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        if (auto_en) begin
            sent_q.push_back(d);
            for (int i = 0; i < 8; i++) exp_q.push_back(d[63-8*i -: 8]);
        end
    endtask

    task automatic manual_bytes(input logic [63:0] blk, input int first_idx, input int last_idx,
                                input int gap, input int first_lat,
                                output logic [7:0] fb, output logic [7:0] lb);
        fb = '0;
        lb = '0;
        for (int i = first_idx; i <= last_idx; i++) begin
            int w = 0;
            int bad = 0;
            logic [7:0] held;
            while (!tx_start && w < 200) begin
                tick();
                w++;
            end
            chk("tx_start_seen", tx_start, 1);
            if (i == first_idx && first_lat >= 0) chk("first_byte_latency", w, first_lat);
            if (i != first_idx) chk("inter_byte_gap", w, 0);
            chk("byte_out_order", byte_out, blk[63-8*i -: 8]);
            if (i == first_idx) fb = byte_out;
            lb   = byte_out;
            held = byte_out;
            repeat (gap) begin
                tick();
                if (tx_start !== 1'b0 || byte_out !== held || busy !== 1'b1) bad++;
            end
            chk("byte_stable_in_wait", bad, 0);
            man_tx_done = 1'b1;
            tick();
            man_tx_done = 1'b0;
        end
        if (last_idx == 7) begin
            chk("block_done_pulse", block_done, 1);
            tick();
            chk("block_done_one_cycle", block_done, 0);
            chk("idle_after_done", busy, 0);
        end
    endtask

    // Behavioural UART model: takes each started byte, checks it against the
    // expected stream and rebuilds blocks the way the receive collector would.
    initial begin : uart_model
        logic [63:0] acc;
        int          n;
        int          d;
        acc = '0;
        n   = 0;
        forever begin
            if (auto_en && tx_start) begin
                chk("uart_byte_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("uart_byte_value", byte_out, exp_q.pop_front());
                acc = {acc[55:0], byte_out};
                n++;
                if (n == 8) begin
                    rx_q.push_back(acc);
                    n = 0;
                end
                d = $urandom_range(gap_max, gap_min);
                repeat (d) tick();
                auto_tx_done = 1'b1;
                tick();
                auto_tx_done = 1'b0;
            end else begin
                tick();
            end
        end
    end

    task automatic drain(input int bd_target);
        int w = 0;
        while ((exp_q.size() != 0 || bd_count < bd_target || busy) && w < 5000) begin
            tick();
            w++;
        end
        chk("drain_timeout", w < 5000, 1);
    endtask

    initial begin : watchdog
        #1000000;
        failures++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [7:0]  fb;
        logic [7:0]  lb;
        logic [7:0]  held;
        logic [63:0] blk;
        int          bd0;
        int          ts0;
        int          bad;
        int          w;

        vecs[0] = '{64'h0123_4567_89AB_CDEF, 10, 8'h01, 8'hEF};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF,  1, 8'hFF, 8'hFF};
        vecs[2] = '{64'h0000_0000_0000_0000,  2, 8'h00, 8'h00};
        vecs[3] = '{64'h8000_0000_0000_0001,  3, 8'h80, 8'h01};

        // Reset state
        repeat (3) tick();
        chk("reset_byte_out", byte_out, 0);
        chk("reset_tx_start", tx_start, 0);
        chk("reset_busy", busy, 0);
        chk("reset_block_done", block_done, 0);
        chk("reset_in_ready", in_ready, 1);
        @(negedge clock);
        reset = 1'b0;
        tick();
        chk("post_reset_busy", busy, 0);

        // Table-driven single blocks; vecs[0] is the reference block
        foreach (vecs[k]) begin
            bd0 = bd_count;
            ts0 = ts_count;
            send_block(vecs[k].data);
            chk("accept_drops_in_ready", in_ready, 0);
            manual_bytes(vecs[k].data, 0, 7, vecs[k].gap, 1, fb, lb);
            chk("vec_first_byte", fb, vecs[k].exp_first);
            chk("vec_last_byte", lb, vecs[k].exp_last);
            chk("vec_tx_start_count", ts_count - ts0, 8);
            chk("vec_block_done_count", bd_count - bd0, 1);
        end

        // Spurious tx_done in IDLE and START
        held = byte_out;
        man_tx_done = 1'b1;
        tick();
        tick();
        man_tx_done = 1'b0;
        chk("spurious_idle_busy", busy, 0);
        chk("spurious_idle_byte", byte_out, held);
        blk = 64'hA1B2_C3D4_E5F6_0718;
        send_block(blk);
        man_tx_done = 1'b1;
        tick();
        chk("spurious_start_pulse", tx_start, 1);
        tick();
        man_tx_done = 1'b0;
        chk("spurious_start_no_shift", byte_out, 8'hA1);
        bad = 0;
        repeat (50) begin
            tick();
            if (byte_out !== 8'hA1 || tx_start !== 1'b0) bad++;
        end
        chk("wait50_byte_stable", bad, 0);
        man_tx_done = 1'b1;
        tick();
        man_tx_done = 1'b0;
        manual_bytes(blk, 1, 7, 3, -1, fb, lb);
        chk("spurious_block_second_byte", fb, 8'hB2);

        // Reset after the third tx_done, with another block held
        blk = 64'h1122_3344_5566_7788;
        send_block(blk);
        manual_bytes(blk, 0, 2, 4, 1, fb, lb);
        send_block(64'hDEAD_BEEF_CAFE_F00D);
        #2;
        reset = 1'b1;
        #1;
        chk("midreset_byte_out", byte_out, 0);
        chk("midreset_tx_start", tx_start, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_block_done", block_done, 0);
        chk("midreset_in_ready", in_ready, 1);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) tick();
        chk("held_block_discarded", busy, 0);
        blk = 64'h5A5A_0F0F_F0F0_A5A5;
        send_block(blk);
        manual_bytes(blk, 0, 7, 2, 1, fb, lb);
        chk("after_reset_msb_first", fb, 8'h5A);

        // tx_done withheld for 1000 cycles
        blk = 64'hCAFE_BABE_1234_5678;
        send_block(blk);
        manual_bytes(blk, 0, 0, 1000, 1, fb, lb);
        manual_bytes(blk, 1, 7, 2, -1, fb, lb);

        // Back-to-back blocks with the automatic UART model
        auto_en = 1'b1;
        gap_min = 10;
        gap_max = 10;
        bd0 = bd_count;
        send_block(64'h0102_0304_0506_0708);
        w = 0;
        while (exp_q.size() > 6 && w < 200) begin
            tick();
            w++;
        end
        chk("b2b_reach_byte2", exp_q.size() <= 6, 1);
        chk("b2b_B_in_ready", in_ready, 1);
        send_block(64'h1112_1314_1516_1718);
        chk("b2b_C_stalls", in_ready, 0);
        w = 0;
        while (!in_ready && w < 500) begin
            tick();
            w++;
        end
        chk("b2b_C_after_A_done", bd_count - bd0, 1);
        send_block(64'h2122_2324_2526_2728);
        drain(bd0 + 3);
        chk("b2b_blocks_done", bd_count - bd0, 3);

        // Randomized loopback
        gap_min = 1;
        gap_max = 6;
        bd0 = bd_count;
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(15, 0)) tick();
            send_block({$urandom(), $urandom()});
        end
        drain(bd0 + 20);
        chk("rand_blocks_done", bd_count - bd0, 20);
        chk("loopback_block_count", rx_q.size(), sent_q.size());
        bad = 0;
        while (rx_q.size() != 0 && sent_q.size() != 0) begin
            if (rx_q.pop_front() !== sent_q.pop_front()) bad++;
        end
        chk("loopback_blocks_equal", bad, 0);
        auto_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
